// File: rtl/data_sram_slave.sv
// Responder end of the core's data-SRAM port: word RAM with byte-lane writes, 1-cycle registered read,
// and sticky out-of-range store capture. Define DSRAM_STATS_EN to build the retired-store counter st_cnt.
module data_sram_slave #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        oor_err,
  output logic [31:0] oor_addr,
  output logic [31:0] st_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // p0: address decode and write-first merge of the addressed word
  logic [31:0]       off_p0;
  logic [ADDR_W-1:0] idx_p0;
  logic              in_range_p0;
  logic              wr_p0;
  logic [31:0]       cur_p0;
  logic [31:0]       merged_p0;

  assign off_p0      = data_sram_addr - BASE_ADDR;
  assign idx_p0      = off_p0[ADDR_W+1:2];
  assign in_range_p0 = (off_p0 >> (ADDR_W + 2)) == 32'd0;
  assign wr_p0       = data_sram_en && (data_sram_we != 4'h0);
  assign cur_p0      = mem[idx_p0];
  assign merged_p0   = merge_lanes(cur_p0, data_sram_wdata, data_sram_we);

  // Array contents survive reset; the reset event only blocks writes while resetn is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn && wr_p0 && in_range_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[idx_p0][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // p1: registered read data and sticky out-of-range store capture
  logic [31:0] rdata_p1;
  logic        oor_err_p1;
  logic [31:0] oor_addr_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_p1 <= 32'h0;
    end else if (data_sram_en) begin
      rdata_p1 <= in_range_p0 ? merged_p0 : 32'h0;
    end
  end

  // Only stores flag: load addresses from non-memory instructions are speculative.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oor_err_p1  <= 1'b0;
      oor_addr_p1 <= 32'h0;
    end else if (wr_p0 && !in_range_p0 && !oor_err_p1) begin
      oor_err_p1  <= 1'b1;
      oor_addr_p1 <= data_sram_addr;
    end
  end

  assign data_sram_rdata = rdata_p1;
  assign oor_err         = oor_err_p1;
  assign oor_addr        = oor_addr_p1;

`ifdef DSRAM_STATS_EN
  logic [31:0] st_cnt_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_cnt_p1 <= 32'h0;
    end else if (wr_p0) begin
      st_cnt_p1 <= st_cnt_p1 + 32'd1;
    end
  end

  assign st_cnt = st_cnt_p1;
`else
  assign st_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed self-checking bench for data_sram_slave (small array, non-zero base to exercise offset wrap).
module tb_data_sram_slave;

  localparam int unsigned AW   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef DSRAM_STATS_EN
  localparam logic [31:0] EXP_ST = 32'd7;
`else
  localparam logic [31:0] EXP_ST = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        oor_err;
  logic [31:0] oor_addr;
  logic [31:0] st_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_sram_en   (en),
    .data_sram_we   (we),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .oor_err        (oor_err),
    .oor_addr       (oor_addr),
    .st_cnt         (st_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one request, clock it in, and settle 1 time unit past the edge.
  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; en = 1'b1; we = 4'hf; addr = BASE; wdata = 32'hffff_ffff;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_oor_err", {31'h0, oor_err}, 32'h0);
    check("rst_oor_addr", oor_addr, 32'h0);
    check("rst_st_cnt", st_cnt, 32'h0);

    en = 1'b0; we = 4'h0;
    resetn = 1'b1;
    acc(1'b1, 4'hf, BASE, 32'h1234_5678);
    check("wr0_readback", rdata, 32'h1234_5678);

    // Store attempted during reset must not touch mem[0].
    en = 1'b1; we = 4'hf; addr = BASE; wdata = 32'hffff_ffff;
    resetn = 1'b0;
    #1;
    check("rst2_async_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst2_st_cnt", st_cnt, 32'h0);
    en = 1'b0; we = 4'h0;
    resetn = 1'b1;
    acc(1'b1, 4'h0, BASE, 32'h0);
    check("mem0_retained", rdata, 32'h1234_5678);

    acc(1'b1, 4'hf, BASE + 32'h10, 32'hdead_beef);
    check("wr_first_rdbk", rdata, 32'hdead_beef);
    acc(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    check("rd_deadbeef", rdata, 32'hdead_beef);
    acc(1'b1, 4'h0, BASE + 32'h13, 32'h0);
    check("rd_addr_lsb_ign", rdata, 32'hdead_beef);

    acc(1'b1, 4'hf, BASE + 32'h20, 32'h1122_3344);
    acc(1'b1, 4'b0101, BASE + 32'h20, 32'haabb_ccdd);
    check("lane_merge_rdbk", rdata, 32'h11bb_33dd);
    acc(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    check("lane_merge_rd", rdata, 32'h11bb_33dd);

    acc(1'b1, 4'hf, BASE + 32'h30, 32'h5);
    acc(1'b1, 4'h0, BASE + 32'h30, 32'h0);
    check("rd_5", rdata, 32'h5);
    acc(1'b0, 4'h0, BASE + 32'h10, 32'h0);
    acc(1'b0, 4'hf, BASE + 32'h30, 32'h9999_9999);
    acc(1'b0, 4'h0, BASE + 32'h20, 32'h0);
    check("en0_hold", rdata, 32'h5);
    acc(1'b1, 4'h0, BASE + 32'h30, 32'h0);
    check("en0_no_write", rdata, 32'h5);
    acc(1'b1, 4'h0, BASE + 32'h800, 32'h0);
    check("oor_rd_rdata", rdata, 32'h0);
    check("oor_rd_no_flag", {31'h0, oor_err}, 32'h0);

    acc(1'b1, 4'hf, BASE + (32'd4 << AW), 32'hcafe_f00d);
    check("oor_wr_rdata", rdata, 32'h0);
    check("oor_err_set", {31'h0, oor_err}, 32'h1);
    check("oor_addr_first", oor_addr, BASE + (32'd4 << AW));
    acc(1'b1, 4'h0, BASE, 32'h0);
    check("oor_wr_dropped", rdata, 32'h1234_5678);
    acc(1'b1, 4'hf, BASE - 32'h4, 32'h0bad_0bad);
    check("oor_wrap_sticky", {31'h0, oor_err}, 32'h1);
    check("oor_addr_kept", oor_addr, BASE + (32'd4 << AW));

    en = 1'b0; we = 4'h0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst3_oor_clr", {31'h0, oor_err}, 32'h0);
    for (int i = 0; i < 6; i++) acc(1'b1, 4'b0001 << (i % 4), BASE + 32'h40 + 32'(i * 4), 32'(i));
    acc(1'b0, 4'hf, BASE + 32'h40, 32'h0);
    acc(1'b1, 4'h0, BASE + 32'h44, 32'h0);
    acc(1'b1, 4'hf, BASE + 32'h1000, 32'h0);
    check("st_cnt", st_cnt, EXP_ST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
